uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
- Parametrised UART receiver and the successor to uart_rx.
- Data width, parity mode and stop-bit count are configurable; a receive FIFO is built in.
- Samples each bit at its centre and flags parity and framing errors per word.
- Sits between the serial pin and an AXI-stream consumer; absorbs bursts up to fifo_depth words.

Parameters:
- cycles_per_bit, 434, clk cycles per serial bit; must be >= 8.
- data_width, 8, data bits per frame; legal 5..9.
- parity, 0, 0 = none, 1 = even, 2 = odd.
- stop_bits, 1, stop bits per frame; legal 1 or 2.
- fifo_depth, 16, receive FIFO entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx  in  1  asynchronous serial input; idle high.
- tready  in  1  consumer ready.
- tvalid  out  1  FIFO head valid.
- tdata  out  data_width  received word, LSB first on the line.
- tuser  out  2  per-word flags: [0] framing_err, [1] parity_err.
- overflow  out  1  one-cycle pulse when a completed word is dropped.
- fifo_level  out  $clog2(fifo_depth)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_n low at a clk edge):
  - tvalid, overflow, fifo_level, tdata and tuser all 0.
  - FIFO emptied; FSM goes to IDLE.
  - Synchroniser flops preset to 1.
  - Reset mid-frame abandons the frame; no partial word is pushed.
- Input sync: rx passes through 2 flops; the FSM sees rx_s only.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. Bit counter and cycle counter are both cleared on every state entry.
  - IDLE: rx_s == 0 -> START.
  - START: at count cycles_per_bit/2, sample rx_s.
    - 1 -> IDLE (glitch, nothing pushed).
    - 0 -> DATA.
  - DATA: sample every cycles_per_bit cycles into a shift register, LSB first. After data_width samples -> PARITY if parity != 0, else STOP.
  - PARITY: one sample. parity_err = (XOR of data bits XOR sample) != (parity == 2).
  - STOP: stop_bits samples; any sample == 0 sets framing_err.
    - After the last sample, push {flags, data} to the FIFO.
    - Then -> IDLE if the last sample was 1, else WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s == 1, then -> IDLE. This covers a break or line held low.
- FIFO push/pop rules:
  - Push occurs in the cycle after the last stop sample.
  - tvalid rises the following cycle: 2 cycles after the last stop sample.
  - tdata and tuser stay stable while tvalid && !tready.
  - Pop on tvalid && tready.
- Full FIFO:
  - A push while full with no pop in the same cycle is dropped and overflow pulses for exactly 1 cycle. FIFO contents are unchanged.
  - Push and pop in the same cycle while full: push accepted, no overflow, level unchanged.
- Empty FIFO: tvalid = 0; tready is ignored.
- Pointers are $clog2(fifo_depth) bits and wrap modulo fifo_depth.
- fifo_level ranges 0..fifo_depth.
- Errored words are still pushed; the consumer decides whether to drop them.

Optional Feature:
- Macro: UART_RX_BREAK_DETECT_EN.
- Defined:
  - Adds output port break_det (1 bit, reset 0).
  - break_det pulses 1 cycle when a frame has all data bits 0, a parity sample of 0 (if parity is enabled) and a stop sample of 0.
  - That frame is not pushed to the FIFO.
- Undefined:
  - No break_det port.
  - Such a frame is pushed with framing_err = 1.

Decomposition:
- Package uart_pkg:
  - parity_t enum: PARITY_NONE, PARITY_EVEN, PARITY_ODD.
  - rx_state_t enum covering the six FSM states.
  - Localparams for the tuser bit indices.
- One sub-module: sync_fifo (data_width+2 bits wide, fifo_depth deep, show-ahead output, level output). It is reusable by the planned uart_tx_fifo.

Test Plan (cycles_per_bit=434, 20 ns clk):
- Defaults; send 0x4D with tready = 1 -> one word tdata = 0x4D, tuser = 0, overflow never set, tvalid low 1 cycle after the pop.
- parity = 1; send 0x07 with a correct parity bit (1) -> tuser = 0; send 0x07 with parity bit 0 -> tuser = 2'b10.
- stop_bits = 2; hold rx low during the second stop bit -> word pushed with tuser = 2'b01; FSM waits in WAIT_IDLE; the next valid frame (0xA5) is received correctly.
- fifo_depth = 4, tready = 0:
  - Send 5 bytes 0x01..0x05 -> fifo_level = 4, one overflow pulse.
  - Then drain with tready = 1 -> 0x01..0x04 in order.
- 200 ns low glitch on idle rx -> no push, tvalid stays 0, FSM back in IDLE.
- Assert rst_n = 0 for 1 cycle mid-way through the data bits of 0x3C -> no word pushed, fifo_level = 0; the next 0x3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive/transmit path.
// Revision    : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam int unsigned c_tuser_framing = 0;
    localparam int unsigned c_tuser_parity  = 1;
    localparam int unsigned c_tuser_w       = 2;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO with occupancy and drop pulse.
// Revision    : 1.0
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_lvl_w = c_ptr_w + 1;
    localparam logic [c_lvl_w-1:0] c_full_level = c_lvl_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_level;
    logic               r_overflow;
    logic               w_empty;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == c_full_level);
    assign w_do_pop  = pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_do_push = push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + c_lvl_w'(1);
                2'b01:   r_level <= r_level - c_lvl_w'(1);
                default: r_level <= r_level;
            endcase
            r_overflow <= push && !w_do_push;
        end
    end

    assign rdata    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign empty    = w_empty;
    assign level    = r_level;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Centre-sampling UART receiver with per-word error flags and an
//               AXI-stream receive FIFO. Macro UART_RX_BREAK_DETECT_EN adds
//               break detection (break_det) and suppresses break frames.
// Revision    : 1.0
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = 434,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned STOP_BITS      = 1,
    parameter int unsigned FIFO_DEPTH     = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    input  logic                        tready,
    output logic                        tvalid,
    output logic [DATA_WIDTH-1:0]       tdata,
    output logic [1:0]                  tuser,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                        break_det
`endif
);
    localparam int unsigned c_cnt_w  = $clog2(CYCLES_PER_BIT);
    localparam int unsigned c_bit_w  = 4;
    localparam int unsigned c_word_w = DATA_WIDTH + c_tuser_w;
    localparam logic [c_cnt_w-1:0] c_half      = c_cnt_w'(CYCLES_PER_BIT / 2);
    localparam logic [c_cnt_w-1:0] c_last      = c_cnt_w'(CYCLES_PER_BIT - 1);
    localparam logic [c_bit_w-1:0] c_data_last = c_bit_w'(DATA_WIDTH - 1);
    localparam logic [c_bit_w-1:0] c_stop_last = c_bit_w'(STOP_BITS - 1);

    logic                  r_rx_meta;
    logic                  r_rx_s;
    rx_state_t             r_state;
    rx_state_t             w_next_state;
    logic [c_cnt_w-1:0]    r_cyc;
    logic [c_bit_w-1:0]    r_bit;
    logic                  w_sample;
    logic                  w_frame_done;
    logic                  w_state_change;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_err;
    logic                  r_frm_err;
    logic                  w_frm_final;
    logic [c_tuser_w-1:0]  w_flags;
    logic [c_word_w-1:0]   r_word;
    logic                  r_push;
    logic [c_word_w-1:0]   w_fifo_rdata;
    logic                  w_fifo_empty;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                  r_par_bit;
    logic                  r_break;
    logic                  w_is_break;
`endif

    // rx is asynchronous; idle-high preset keeps reset from looking like a start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_rx_s) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (r_cyc == c_half) begin
                    w_next_state = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_cyc == c_last) begin
                    w_sample = 1'b1;
                    if (r_bit == c_data_last) begin
                        w_next_state = (PARITY != int'(PARITY_NONE)) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (r_cyc == c_last) begin
                    w_sample     = 1'b1;
                    w_next_state = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cyc == c_last) begin
                    w_sample = 1'b1;
                    if (r_bit == c_stop_last) begin
                        w_frame_done = 1'b1;
                        w_next_state = r_rx_s ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (r_rx_s) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_state_change = (w_next_state != r_state);
    assign w_frm_final    = r_frm_err | !r_rx_s;

    always_comb begin
        w_flags                  = '0;
        w_flags[c_tuser_framing] = w_frm_final;
        w_flags[c_tuser_parity]  = r_par_err;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    assign w_is_break = (r_shift == '0) && !r_par_bit && w_frm_final;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cyc     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_word    <= '0;
            r_push    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_par_bit <= 1'b0;
            r_break   <= 1'b0;
`endif
        end else begin
            r_push <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_break <= 1'b0;
`endif
            // Cycle counter restarts on every state entry and after each sample.
            if (w_state_change || w_sample) begin
                r_cyc <= '0;
            end else begin
                r_cyc <= r_cyc + c_cnt_w'(1);
            end
            if (w_state_change) begin
                r_bit <= '0;
            end else if (w_sample) begin
                r_bit <= r_bit + c_bit_w'(1);
            end

            if (r_state == ST_IDLE) begin
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                r_par_bit <= 1'b0;
`endif
            end

            if (w_sample) begin
                case (r_state)
                    ST_DATA: r_shift <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                    ST_PARITY: begin
                        r_par_err <= ((^r_shift) ^ r_rx_s) != (PARITY == int'(PARITY_ODD));
`ifdef UART_RX_BREAK_DETECT_EN
                        r_par_bit <= r_rx_s;
`endif
                    end
                    ST_STOP: begin
                        if (!r_rx_s) begin
                            r_frm_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_frame_done) begin
                r_word <= {w_flags, r_shift};
`ifdef UART_RX_BREAK_DETECT_EN
                r_push  <= !w_is_break;
                r_break <= w_is_break;
`else
                r_push  <= 1'b1;
`endif
            end
        end
    end

    sync_fifo #(
        .WIDTH (c_word_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (r_push),
        .wdata    (r_word),
        .pop      (tready),
        .rdata    (w_fifo_rdata),
        .empty    (w_fifo_empty),
        .level    (fifo_level),
        .overflow (overflow)
    );

    assign tvalid = !w_fifo_empty;
    assign tdata  = w_fifo_rdata[DATA_WIDTH-1:0];
    assign tuser  = w_fifo_rdata[DATA_WIDTH +: c_tuser_w];
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det = r_break;
`endif

endmodule
`default_nettype wire
